ifetch: RTL
===========

// Module: ifetch
// PURPOSE
//  Instruction fetch stage of the 16-bit core; sits directly upstream of the instruction register.
//  Owns the program counter and issues one request per fetch to instruction memory over a req/ack handshake.
//  Returns the fetched word on ins_out with a one-cycle il_out load strobe for the IR.
//  Supports PC redirect (branch/jump), flush of an in-flight fetch, and a sticky ack-timeout error.
// PARAMETERS
//  RESET_PC  16'h0000  PC value after reset
//  PC_STEP   1         PC increment per completed fetch (1 = word addressed)
//  TIMEOUT   255       max cycles in REQ without ack before error; 0 disables timeout
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  fetch_req   in   1   control: start one fetch (sampled only in IDLE)
//  pc_ld       in   1   control: load PC from pc_in (redirect)
//  pc_in       in   16  redirect target
//  imem_req    out  1   memory request, registered
//  imem_addr   out  16  memory address, registered, stable while imem_req=1
//  imem_ack    in   1   memory accept; imem_rdata valid in same cycle
//  imem_rdata  in   16  instruction word
//  ins_out     out  16  last fetched instruction (to IR ins_in)
//  il_out      out  1   one-cycle load strobe (to IR il_in)
//  pc_out      out  16  current PC
//  busy        out  1   1 in REQ
//  fetch_err   out  1   sticky ack-timeout flag
// BEHAVIOUR
//  Reset: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, ins_out=0, il_out=0, busy=0, fetch_err=0, flush=0, tmo_cnt=0.
//  States: IDLE, REQ, ERR.
//  IDLE: pc_ld -> pc<=pc_in. fetch_req -> addr<=(pc_ld ? pc_in : pc), imem_req<=1, state REQ (both may occur in one cycle).
//  REQ: imem_req held 1, addr held until ack. fetch_req ignored.
//   ack, flush=0, pc_ld=0: ins_out<=imem_rdata; il_out=1 next cycle only; pc<=pc+PC_STEP (mod 2^16, FFFF->0000); imem_req<=0; IDLE.
//   pc_ld (no ack): pc<=pc_in, flush<=1; request stays outstanding.
//   ack with flush=1 or pc_ld same cycle: data discarded, no il_out, ins_out unchanged; pc<=(pc_ld ? pc_in : pc);
//     addr<=that same value, imem_req stays 1, flush<=0, tmo_cnt<=0, remain REQ (automatic refetch at target).
//   tmo_cnt increments each REQ cycle without ack; clears on ack; when TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with no ack -> ERR.
//  ERR: imem_req=0, fetch_err=1, busy=0; ignores all inputs except reset.
//  Fetch latency: fetch_req at edge N -> imem_req high after N; ack at edge M -> il_out high for the cycle after M.
//  imem_ack while imem_req=0 is ignored. busy = (state==REQ).
//  Reset mid-fetch: all state to reset values immediately; a late ack is ignored.
// STRUCTURE
//  mycpu_pkg: typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_ERR} fetch_state_t; localparam PC_W=16.
//  Sub-module pc_reg: PC register with reset value, load and increment-by-PC_STEP; FSM, addr/flush/timeout in ifetch.
// TESTING
//  Basic: reset, fetch_req, ack 2 cycles later with rdata=16'h1234 -> ins_out=1234, il_out 1 cycle, pc_out 0000->0001.
//  Redirect in IDLE: pc_ld pc_in=16'h0040 with fetch_req same cycle -> imem_addr=0040; after ack pc_out=0041.
//  Flush: fetch at 0005, pc_ld 0080 before ack, ack rdata=DEAD -> no il_out, imem_addr=0080; ack BEEF -> ins_out=BEEF, pc=0081.
//  Wrap: RESET_PC=16'hFFFF, one fetch -> imem_addr=FFFF, pc_out=0000.
//  Timeout: TIMEOUT=4, never ack -> fetch_err=1 after 4 REQ cycles, imem_req=0, later fetch_req ignored.
//  Reset mid-fetch: rst_n low during REQ, ack afterward -> imem_req=0, pc=RESET_PC, il_out never asserted.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared types and widths for the 16-bit core front end.
package mycpu_pkg;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned TMO_W = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_ERR  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Program counter register: reset value, direct load, and fixed-step increment.
module pc_reg
  import mycpu_pkg::*;
#(
  parameter pc_t         RESET_PC = '0,
  parameter int unsigned PC_STEP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld,
  input  pc_t  ld_val,
  input  logic inc,
  output pc_t  pc
);

  // Load wins over increment; the increment wraps modulo 2^PC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + PC_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, fetches one word per request over req/ack,
// supports redirect/flush of an outstanding fetch and a sticky ack-timeout error.
module ifetch
  import mycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        pc_ld,
  input  logic [15:0] pc_in,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ins_out,
  output logic        il_out,
  output logic [15:0] pc_out,
  output logic        busy,
  output logic        fetch_err
);

  fetch_state_t     state, state_n;
  logic             req_n;
  pc_t              addr_n;
  pc_t              ins_n;
  logic             il_n;
  logic             err_n;
  logic             busy_n;
  logic             flush, flush_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic             pc_ld_c;
  logic             pc_inc_c;
  logic             tmo_hit_c;
  pc_t              pc;

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (pc_ld_c),
    .ld_val (pc_in),
    .inc    (pc_inc_c),
    .pc     (pc)
  );

  assign pc_out    = pc;
  assign tmo_hit_c = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FS_IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ins_out   <= '0;
      il_out    <= 1'b0;
      fetch_err <= 1'b0;
      busy      <= 1'b0;
      flush     <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      ins_out   <= ins_n;
      il_out    <= il_n;
      fetch_err <= err_n;
      busy      <= busy_n;
      flush     <= flush_n;
      tmo_cnt   <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    req_n    = imem_req;
    addr_n   = imem_addr;
    ins_n    = ins_out;
    il_n     = 1'b0;
    err_n    = fetch_err;
    flush_n  = flush;
    tmo_n    = tmo_cnt;
    pc_ld_c  = 1'b0;
    pc_inc_c = 1'b0;

    unique case (state)
      FS_IDLE: begin
        pc_ld_c = pc_ld;
        if (fetch_req) begin
          addr_n  = pc_ld ? pc_in : pc;
          req_n   = 1'b1;
          flush_n = 1'b0;
          tmo_n   = '0;
          state_n = FS_REQ;
        end
      end

      FS_REQ: begin
        if (imem_ack) begin
          tmo_n = '0;
          // A redirect seen before or with the ack turns the response into a refetch.
          if (flush || pc_ld) begin
            pc_ld_c = pc_ld;
            addr_n  = pc_ld ? pc_in : pc;
            flush_n = 1'b0;
          end else begin
            ins_n    = imem_rdata;
            il_n     = 1'b1;
            pc_inc_c = 1'b1;
            req_n    = 1'b0;
            state_n  = FS_IDLE;
          end
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
          if (pc_ld) begin
            pc_ld_c = 1'b1;
            flush_n = 1'b1;
          end
          if (tmo_hit_c) begin
            req_n   = 1'b0;
            err_n   = 1'b1;
            flush_n = 1'b0;
            state_n = FS_ERR;
          end
        end
      end

      FS_ERR: begin
        req_n = 1'b0;
      end

      default: begin
        req_n   = 1'b0;
        state_n = FS_IDLE;
      end
    endcase

    busy_n = (state_n == FS_REQ);
  end

endmodule
